// File: rtl/cmd_frame_pkg.sv
// Shared constants and state encoding for the command/reply framing logic.
// Used by both the command identifier and the reply transmitter.

`ifndef UART_FIFO_COUNTER_W
`define UART_FIFO_COUNTER_W 5
`endif

package cmd_frame_pkg;

   // Fixed frame bytes
   localparam logic [7:0] HDR0     = 8'hEB;
   localparam logic [7:0] HDR1     = 8'h90;
   localparam logic [7:0] BOARD_ID = 8'hAB;
   localparam logic [7:0] TAIL0    = 8'h09;
   localparam logic [7:0] TAIL1    = 8'hD7;
   localparam logic [7:0] ERR_CODE = 8'hEE;

   localparam int unsigned FRAME_LEN = 8;

   // One-hot reply transmitter states
   typedef enum logic [3:0] {
      ST_IDLE = 4'b0001,
      ST_REQ  = 4'b0010,
      ST_PUSH = 4'b0100,
      ST_GAP  = 4'b1000
   } reply_state_e;

   // Status byte: {ok, switch, pwr_a, pwr_b, rst_a, rst_b, 2'b00}
   function automatic logic [7:0] pack_status(
      input logic ok,
      input logic sw,
      input logic pwr_a,
      input logic pwr_b,
      input logic rst_a,
      input logic rst_b
   );
      return {ok, sw, pwr_a, pwr_b, rst_a, rst_b, 2'b00};
   endfunction

endpackage

// File: rtl/reply_frame_builder.sv
// Combinational byte selector for the 8-byte reply frame. The checksum is
// derived from the frozen code and status bytes so bytes 2..5 sum to zero.

module reply_frame_builder
   import cmd_frame_pkg::*;
(
   input  logic [7:0] i_code,
   input  logic [7:0] i_status,
   input  logic [2:0] i_idx,
   output logic [7:0] o_byte
);

   logic [7:0] w_checksum;

   assign w_checksum = 8'h00 - (BOARD_ID + i_code + i_status);

   // Select the frame byte addressed by i_idx
   always_comb begin
      // NOTE: default assignment first so no path leaves o_byte unassigned (no latch).
      o_byte = HDR0;
      case (i_idx)
         3'd0:    o_byte = HDR0;
         3'd1:    o_byte = HDR1;
         3'd2:    o_byte = BOARD_ID;
         3'd3:    o_byte = i_code;
         3'd4:    o_byte = i_status;
         3'd5:    o_byte = w_checksum;
         3'd6:    o_byte = TAIL0;
         3'd7:    o_byte = TAIL1;
         default: o_byte = HDR0;
      endcase
   end

endmodule

// File: rtl/cmd_reply_tx.sv
// Reply frame transmitter: snapshots the command check result and board
// status, requests the shared UART TX FIFO, then pushes 8 bytes, one every
// two clocks, stalling on loss of grant or a full FIFO.

module cmd_reply_tx
   import cmd_frame_pkg::*;
#(
   parameter int FIFO_DEPTH = 16,
   parameter int CNT_W      = `UART_FIFO_COUNTER_W
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_done,
   input  logic             cmd_ok,
   input  logic [7:0]       cmd_code,
   input  logic             switch,
   input  logic             power_on_A,
   input  logic             power_on_B,
   input  logic             reset_a_signal,
   input  logic             reset_b_signal,
   input  logic [CNT_W-1:0] tf_counter,
   input  logic             tx_gnt,
   output logic             tx_req,
   output logic             tf_push,
   output logic [7:0]       tdr,
   output logic             busy,
   output logic [7:0]       drop_cnt
);

   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

   reply_state_e r_state;
   logic [2:0]   r_idx;
   logic         r_pend;
   logic         r_pend_ok;
   logic [7:0]   r_pend_code;
   logic [7:0]   r_code;
   logic [7:0]   r_status;
   logic         r_tx_req;
   logic         r_tf_push;
   logic [7:0]   r_tdr;
   logic [7:0]   r_drop_cnt;

   logic         w_room;
   logic         w_sel_ok;
   logic [7:0]   w_sel_code;
   logic [7:0]   w_byte;

   assign w_room     = (tf_counter < DEPTH_CNT);
   // A pending request replays the check result captured with its cmd_done;
   // board status is always taken live at the accepting edge.
   assign w_sel_ok   = r_pend ? r_pend_ok   : cmd_ok;
   assign w_sel_code = r_pend ? r_pend_code : cmd_code;

   reply_frame_builder u_builder (
      .i_code   (r_code),
      .i_status (r_status),
      .i_idx    (r_idx),
      .o_byte   (w_byte)
   );

   // Request queueing, drop counting and the frame transmit FSM
   always_ff @(posedge clk) begin
      // NOTE: every register, including the snapshot and pending payload, is
      // reset so an aborted frame leaves no stale state behind.
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_idx       <= 3'd0;
         r_pend      <= 1'b0;
         r_pend_ok   <= 1'b0;
         r_pend_code <= 8'h00;
         r_code      <= 8'h00;
         r_status    <= 8'h00;
         r_tx_req    <= 1'b0;
         r_tf_push   <= 1'b0;
         r_tdr       <= 8'h00;
         r_drop_cnt  <= 8'h00;
      end else begin
         // NOTE: non-blocking assignments only; later assignments in this
         // block override earlier defaults without ordering hazards.
         r_tf_push <= 1'b0;

         if (cmd_done) begin
            if (r_pend) begin
               if (r_drop_cnt != 8'hFF) begin
                  r_drop_cnt <= r_drop_cnt + 8'd1;
               end
            end else if (r_state != ST_IDLE) begin
               r_pend      <= 1'b1;
               r_pend_ok   <= cmd_ok;
               r_pend_code <= cmd_code;
            end
         end

         case (r_state)
            ST_IDLE: begin
               if (cmd_done || r_pend) begin
                  r_code   <= w_sel_ok ? w_sel_code : ERR_CODE;
                  r_status <= pack_status(w_sel_ok, switch, power_on_A, power_on_B,
                                          reset_a_signal, reset_b_signal);
                  r_pend   <= 1'b0;
                  r_tx_req <= 1'b1;
                  r_state  <= ST_REQ;
               end
            end
            ST_REQ: begin
               if (tx_gnt) begin
                  r_idx   <= 3'd0;
                  r_state <= ST_PUSH;
               end
            end
            ST_PUSH: begin
               if (tx_gnt && w_room) begin
                  r_tf_push <= 1'b1;
                  r_tdr     <= w_byte;
                  r_state   <= ST_GAP;
               end
            end
            ST_GAP: begin
               if (r_idx == 3'd7) begin
                  r_tx_req <= 1'b0;
                  r_state  <= ST_IDLE;
               end else begin
                  r_idx   <= r_idx + 3'd1;
                  r_state <= ST_PUSH;
               end
            end
            default: begin
               r_tx_req <= 1'b0;
               r_state  <= ST_IDLE;
            end
         endcase
      end
   end

   assign tx_req   = r_tx_req;
   assign tf_push  = r_tf_push;
   assign tdr      = r_tdr;
   assign drop_cnt = r_drop_cnt;
   assign busy     = (r_state != ST_IDLE) | r_pend;

endmodule

// File: tb/tb_cmd_reply_tx.sv
// Self-checking bench for cmd_reply_tx: expected bytes are queued when a
// command is issued and popped as the DUT pushes to the TX FIFO.

module tb_cmd_reply_tx;

   localparam int FIFO_DEPTH = 16;
   localparam int CNT_W      = 5;

   logic             clk;
   logic             rst_n;
   logic             cmd_done;
   logic             cmd_ok;
   logic [7:0]       cmd_code;
   logic             sw;
   logic             power_on_A;
   logic             power_on_B;
   logic             reset_a_signal;
   logic             reset_b_signal;
   logic [CNT_W-1:0] tf_counter;
   logic             tx_gnt;
   logic             tx_req;
   logic             tf_push;
   logic [7:0]       tdr;
   logic             busy;
   logic [7:0]       drop_cnt;

   int         n_vec = 0;
   int         n_err = 0;
   int         cyc   = 0;
   bit         prev_push = 1'b0;
   logic [7:0] sb[$];
   logic [7:0] got[$];
   int         push_cycs[$];

   cmd_reply_tx #(.FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .cmd_done       (cmd_done),
      .cmd_ok         (cmd_ok),
      .cmd_code       (cmd_code),
      .switch         (sw),
      .power_on_A     (power_on_A),
      .power_on_B     (power_on_B),
      .reset_a_signal (reset_a_signal),
      .reset_b_signal (reset_b_signal),
      .tf_counter     (tf_counter),
      .tx_gnt         (tx_gnt),
      .tx_req         (tx_req),
      .tf_push        (tf_push),
      .tdr            (tdr),
      .busy           (busy),
      .drop_cnt       (drop_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance one cycle, sample at the falling edge and score any push.
   task automatic tick();
      logic [7:0] e;
      @(negedge clk);
      cyc++;
      if (tf_push === 1'b1) begin
         n_vec++;
         if (prev_push) begin
            n_err++;
            $display("FAIL push_spacing: tf_push high on consecutive cycles at cyc %0d", cyc);
         end
         if (sb.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_push: got tdr=%02h, expected no push (cyc %0d)", tdr, cyc);
         end else begin
            e = sb.pop_front();
            if (tdr !== e) begin
               n_err++;
               $display("FAIL frame_byte: got %02h, expected %02h (cyc %0d)", tdr, e, cyc);
            end
         end
         got.push_back(tdr);
         push_cycs.push_back(cyc);
      end
      prev_push = (tf_push === 1'b1);
   endtask

   // Independent model of a reply frame, queued as expected bytes.
   task automatic expect_frame(input logic ok, input logic [7:0] code);
      logic [7:0] b3, b4, b5;
      int         s;
      b3 = ok ? code : 8'hEE;
      b4 = 8'h00;
      b4[7] = ok; b4[6] = sw; b4[5] = power_on_A; b4[4] = power_on_B;
      b4[3] = reset_a_signal; b4[2] = reset_b_signal;
      s  = (int'(8'hAB) + int'(b3) + int'(b4)) % 256;
      b5 = 8'((256 - s) % 256);
      sb.push_back(8'hEB); sb.push_back(8'h90); sb.push_back(8'hAB); sb.push_back(b3);
      sb.push_back(b4);    sb.push_back(b5);    sb.push_back(8'h09); sb.push_back(8'hD7);
   endtask

   // Raise cmd_done for one sampling edge; returns the index of that edge.
   task automatic pulse_cmd(input logic ok, input logic [7:0] code, output int edge_n);
      cmd_ok   = ok;
      cmd_code = code;
      cmd_done = 1'b1;
      edge_n   = cyc + 1;
      tick();
      cmd_done = 1'b0;
   endtask

   task automatic wait_pushes(input int n, input int budget);
      for (int i = 0; i < budget && push_cycs.size() < n; i++) tick();
      n_vec++;
      if (push_cycs.size() < n) begin
         n_err++;
         $display("FAIL wait_pushes: saw %0d pushes, expected %0d within %0d cycles",
                  push_cycs.size(), n, budget);
      end
   endtask

   task automatic wait_idle(input int budget);
      for (int i = 0; i < budget && !(sb.size() == 0 && busy === 1'b0); i++) tick();
      n_vec++;
      if (sb.size() != 0 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL wait_idle: %0d bytes outstanding, busy=%b, expected 0 and 0",
                  sb.size(), busy);
      end
   endtask

   task automatic clear_log();
      got.delete();
      push_cycs.delete();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) tick();
      n_vec++;
      if ({tx_req, tf_push, busy} !== 3'b000) begin
         n_err++;
         $display("FAIL reset_ctrl: tx_req/tf_push/busy=%b, expected 000", {tx_req, tf_push, busy});
      end
      n_vec++;
      if (tdr !== 8'h00) begin
         n_err++;
         $display("FAIL reset_tdr: got %02h, expected 00", tdr);
      end
      n_vec++;
      if (drop_cnt !== 8'h00) begin
         n_err++;
         $display("FAIL reset_drop: got %02h, expected 00", drop_cnt);
      end
      rst_n = 1'b1;
      repeat (2) tick();
   endtask

   task automatic test_basic();
      logic [7:0] f [8] = '{8'hEB, 8'h90, 8'hAB, 8'h0A, 8'hB0, 8'h9B, 8'h09, 8'hD7};
      int en;
      clear_log();
      sw = 1'b0; power_on_A = 1'b1; power_on_B = 1'b1;
      reset_a_signal = 1'b0; reset_b_signal = 1'b0;
      for (int i = 0; i < 8; i++) sb.push_back(f[i]);
      pulse_cmd(1'b1, 8'h0A, en);
      n_vec++;
      if (tx_req !== 1'b1 || busy !== 1'b1) begin
         n_err++;
         $display("FAIL basic_req: tx_req=%b busy=%b after cmd_done, expected 1 1", tx_req, busy);
      end
      wait_idle(40);
      for (int i = 0; i < 8; i++) begin
         n_vec++;
         if (i >= push_cycs.size() || push_cycs[i] != en + 2 + 2 * i) begin
            n_err++;
            $display("FAIL basic_timing: byte %0d push cycle %0d, expected %0d", i,
                     (i < push_cycs.size()) ? push_cycs[i] : -1, en + 2 + 2 * i);
         end
      end
   endtask

   task automatic test_error_frame();
      logic [7:0] f [8] = '{8'hEB, 8'h90, 8'hAB, 8'hEE, 8'h70, 8'hF7, 8'h09, 8'hD7};
      logic [7:0] s;
      int en;
      clear_log();
      sw = 1'b1; power_on_A = 1'b1; power_on_B = 1'b1;
      for (int i = 0; i < 8; i++) sb.push_back(f[i]);
      pulse_cmd(1'b0, 8'hA0, en);
      wait_idle(40);
      n_vec++;
      if (got.size() != 8) begin
         n_err++;
         $display("FAIL err_len: got %0d bytes, expected 8", got.size());
      end else begin
         s = got[2] + got[3] + got[4] + got[5];
         if (s !== 8'h00) begin
            n_err++;
            $display("FAIL err_checksum: bytes 2..5 sum to %02h, expected 00", s);
         end
      end
   endtask

   task automatic test_fifo_full();
      int en;
      clear_log();
      sw = 1'b0;
      expect_frame(1'b1, 8'h3C);
      pulse_cmd(1'b1, 8'h3C, en);
      wait_pushes(3, 20);
      tick();
      tf_counter = CNT_W'(FIFO_DEPTH);
      repeat (10) tick();
      n_vec++;
      if (push_cycs.size() != 3 || tx_req !== 1'b1) begin
         n_err++;
         $display("FAIL full_stall: %0d pushes, tx_req=%b during stall, expected 3 and 1",
                  push_cycs.size(), tx_req);
      end
      tf_counter = '0;
      wait_idle(40);
      n_vec++;
      if (push_cycs.size() != 8 || push_cycs[3] != en + 18 || push_cycs[7] != en + 26) begin
         n_err++;
         $display("FAIL full_timing: byte3 at %0d byte7 at %0d, expected %0d %0d",
                  (push_cycs.size() > 3) ? push_cycs[3] : -1,
                  (push_cycs.size() > 7) ? push_cycs[7] : -1, en + 18, en + 26);
      end
   endtask

   task automatic test_back_to_back();
      int en, early_idle;
      clear_log();
      early_idle = 0;
      cmd_ok = 1'b1; cmd_code = 8'h55;
      expect_frame(1'b1, 8'h55);
      expect_frame(1'b1, 8'h55);
      en = cyc + 1;
      for (int p = 0; p < 3; p++) begin
         cmd_done = 1'b1;
         tick();
         cmd_done = 1'b0;
         tick();
         tick();
      end
      for (int i = 0; i < 60 && push_cycs.size() < 16; i++) begin
         tick();
         if (busy !== 1'b1) early_idle++;
      end
      n_vec++;
      if (early_idle != 0) begin
         n_err++;
         $display("FAIL b2b_busy: busy low %0d cycles before 2nd frame done, expected 0", early_idle);
      end
      wait_idle(10);
      n_vec++;
      if (drop_cnt !== 8'd1) begin
         n_err++;
         $display("FAIL b2b_drop: drop_cnt=%0d, expected 1", drop_cnt);
      end
      n_vec++;
      if (push_cycs.size() != 16 || push_cycs[8] - push_cycs[7] != 4) begin
         n_err++;
         $display("FAIL b2b_gap: %0d pushes, inter-frame gap %0d, expected 16 and 4",
                  push_cycs.size(),
                  (push_cycs.size() > 8) ? push_cycs[8] - push_cycs[7] : -1);
      end
   endtask

   task automatic test_gnt_drop();
      int en;
      clear_log();
      reset_a_signal = 1'b1;
      expect_frame(1'b1, 8'hC3);
      pulse_cmd(1'b1, 8'hC3, en);
      wait_pushes(5, 20);
      tick();
      tx_gnt = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_vec++;
         if (tx_req !== 1'b1) begin
            n_err++;
            $display("FAIL gnt_hold: tx_req=%b while grant low, expected 1", tx_req);
         end
      end
      tx_gnt = 1'b1;
      wait_idle(30);
      n_vec++;
      if (push_cycs.size() != 8 || push_cycs[5] != en + 17) begin
         n_err++;
         $display("FAIL gnt_resume: %0d pushes, byte5 at %0d, expected 8 and %0d",
                  push_cycs.size(), (push_cycs.size() > 5) ? push_cycs[5] : -1, en + 17);
      end
      reset_a_signal = 1'b0;
   endtask

   task automatic test_final_gap();
      int en;
      clear_log();
      reset_b_signal = 1'b1;
      expect_frame(1'b0, 8'h11);
      pulse_cmd(1'b0, 8'h11, en);
      wait_pushes(8, 30);
      expect_frame(1'b1, 8'h22);
      cmd_ok = 1'b1; cmd_code = 8'h22; cmd_done = 1'b1;
      tick();
      cmd_done = 1'b0;
      n_vec++;
      if (busy !== 1'b1) begin
         n_err++;
         $display("FAIL gap_pend: busy=%b after cmd_done in final gap, expected 1", busy);
      end
      wait_idle(40);
      n_vec++;
      if (push_cycs.size() != 16 || push_cycs[8] != en + 20) begin
         n_err++;
         $display("FAIL gap_restart: %0d pushes, next frame byte0 at %0d, expected 16 and %0d",
                  push_cycs.size(), (push_cycs.size() > 8) ? push_cycs[8] : -1, en + 20);
      end
      reset_b_signal = 1'b0;
   endtask

   task automatic test_reset_mid();
      int en;
      clear_log();
      expect_frame(1'b1, 8'h77);
      pulse_cmd(1'b1, 8'h77, en);
      wait_pushes(3, 20);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      sb.delete();
      n_vec++;
      if ({tx_req, tf_push, busy} !== 3'b000 || tdr !== 8'h00 || drop_cnt !== 8'h00) begin
         n_err++;
         $display("FAIL rst_mid_outputs: req/push/busy=%b tdr=%02h drop=%02h, expected 000 00 00",
                  {tx_req, tf_push, busy}, tdr, drop_cnt);
      end
      repeat (20) tick();
      n_vec++;
      if (push_cycs.size() != 3 || tx_req !== 1'b0) begin
         n_err++;
         $display("FAIL rst_mid_quiet: %0d pushes, tx_req=%b, expected 3 and 0",
                  push_cycs.size(), tx_req);
      end
   endtask

   initial begin
      rst_n = 1'b0; cmd_done = 1'b0; cmd_ok = 1'b0; cmd_code = 8'h00;
      sw = 1'b0; power_on_A = 1'b0; power_on_B = 1'b0;
      reset_a_signal = 1'b0; reset_b_signal = 1'b0;
      tf_counter = '0; tx_gnt = 1'b1;
      test_reset();
      test_basic();
      test_error_frame();
      test_fifo_full();
      test_back_to_back();
      test_gnt_drop();
      test_final_gap();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
